// File: rtl/profiler_trigger_pkg.sv
`default_nettype none
// ============================================================================
// Module      : taiga_types (package)
// Description : Shared types for the hot-loop profiler and the exception
//               codes it raises into the global-control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package taiga_types;

   localparam int PROFILER_COUNT_W = 10;

   // Profiler trigger state machine encoding
   typedef enum logic [1:0] {
      PROF_IDLE     = 2'd0,
      PROF_ARMED    = 2'd1,
      PROF_WAIT_ACK = 2'd2
   } profiler_state_t;

   // Software-visible view of one loop-table entry
   typedef struct packed {
      logic                        valid;
      logic [31:0]                 tag;
      logic [31:0]                 end_pc;
      logic [PROFILER_COUNT_W-1:0] count;
   } profiler_entry_t;

   // Exception causes delivered to gc_unit
   typedef enum logic [4:0] {
      INST_ADDR_MISSALIGNED = 5'd0,
      INST_ACCESS_FAULT     = 5'd1,
      ILLEGAL_INST          = 5'd2,
      BREAKPOINT            = 5'd3,
      LOAD_ADDR_MISSALIGNED = 5'd4,
      LOAD_FAULT            = 5'd5,
      STORE_AMO_ADDR_MISSALIGNED = 5'd6,
      STORE_AMO_FAULT       = 5'd7,
      ECALL_U               = 5'd8,
      ECALL_S               = 5'd9,
      ECALL_M               = 5'd11,
      PROFILER_EXCEPTION    = 5'd24
   } exception_code_t;

endpackage
`default_nettype wire

// File: rtl/profiler_cam.sv
`default_nettype none
// ============================================================================
// Module      : profiler_cam
// Description : Fully-associative tag match for the loop table. Produces the
//               hit one-hot/index and the lowest-index free slot.
// Revision    : 1.0 - initial release
// ============================================================================
module profiler_cam #(
   parameter int ENTRIES = 8,
   parameter int IDX_W   = $clog2(ENTRIES)
) (
   input  logic [ENTRIES-1:0]    valid,
   input  logic [ENTRIES*32-1:0] tags,
   input  logic [31:0]           key,
   output logic                  hit,
   output logic [ENTRIES-1:0]    hit_onehot,
   output logic [IDX_W-1:0]      hit_idx,
   output logic                  free_any,
   output logic [IDX_W-1:0]      free_idx
);

   generate
      for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_cmp
         assign hit_onehot[gi] = valid[gi] && (tags[gi*32 +: 32] == key);
      end
   endgenerate

   assign hit      = |hit_onehot;
   assign free_any = ~&valid;

   // Encode the hit line and the lowest-index invalid line
   always_comb begin
      hit_idx  = '0;
      free_idx = '0;
      for (int i = ENTRIES-1; i >= 0; i--) begin
         if (hit_onehot[i]) hit_idx  = IDX_W'(i);
         if (!valid[i])     free_idx = IDX_W'(i);
      end
   end

endmodule
`default_nettype wire

// File: rtl/profiler_trigger.sv
`default_nettype none
// ============================================================================
// Module      : profiler_trigger
// Description : Hot-loop detector. Counts taken backward branches per loop
//               target and raises a one-cycle profiler_exception when a
//               target reaches THRESHOLD, holding the loop bounds for the
//               handler until it acknowledges.
// Revision    : 1.0 - initial release
// ============================================================================
module profiler_trigger
   import taiga_types::*;
#(
   parameter int ENTRIES   = 8,
   parameter int COUNT_W   = 10,
   parameter int THRESHOLD = 512
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        table_clear,
   input  logic        br_valid,
   input  logic        br_taken,
   input  logic [31:0] br_pc,
   input  logic [31:0] br_target,
   input  logic        fire_block,
   input  logic        handler_ack,
   output logic        profiler_exception,
   output logic [31:0] hot_start,
   output logic [31:0] hot_end,
   output logic        busy
);

   localparam int                 IDX_W       = $clog2(ENTRIES);
   localparam logic [COUNT_W-1:0] C_THRESHOLD = COUNT_W'(THRESHOLD);

   // Loop table. An entry's loop end is only ever observed on the cycle it is
   // written, so the trigger latches it straight from br_pc.
   logic [ENTRIES-1:0]    r_valid;
   logic [31:0]           r_tag   [ENTRIES];
   logic [COUNT_W-1:0]    r_count [ENTRIES];
   logic [IDX_W-1:0]      r_victim;

   profiler_state_t       r_state;
   profiler_state_t       w_next_state;

   logic [ENTRIES*32-1:0] w_tags;
   logic                  w_hit;
   logic [ENTRIES-1:0]    w_hit_onehot;
   logic [IDX_W-1:0]      w_hit_idx;
   logic                  w_free_any;
   logic [IDX_W-1:0]      w_free_idx;

   logic                  w_cand;
   logic [IDX_W-1:0]      w_sel_idx;
   logic [COUNT_W-1:0]    w_cur_count;
   logic [COUNT_W-1:0]    w_new_count;
   logic                  w_at_thresh;
   logic                  w_fire;

   generate
      for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_tags
         assign w_tags[gi*32 +: 32] = r_tag[gi];
      end
   endgenerate

   profiler_cam #(
      .ENTRIES (ENTRIES),
      .IDX_W   (IDX_W)
   ) u_cam (
      .valid      (r_valid),
      .tags       (w_tags),
      .key        (br_target),
      .hit        (w_hit),
      .hit_onehot (w_hit_onehot),
      .hit_idx    (w_hit_idx),
      .free_any   (w_free_any),
      .free_idx   (w_free_idx)
   );

   assign w_cand = br_valid && br_taken && enable && (br_target < br_pc);

   // Pick the entry to update and form its next count. Counts stop at
   // THRESHOLD, so a target that crossed it while a trigger was outstanding
   // stays there and matches again on its next candidate after the ack.
   always_comb begin
      w_sel_idx   = w_hit ? w_hit_idx : (w_free_any ? w_free_idx : r_victim);
      w_cur_count = w_hit ? r_count[w_hit_idx] : '0;
      w_new_count = (w_cur_count >= C_THRESHOLD) ? C_THRESHOLD
                                                 : w_cur_count + COUNT_W'(1);
      w_at_thresh = w_cand && !table_clear && (w_new_count == C_THRESHOLD);
   end

   // Loop table update; a clear overrides any lookup in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid  <= '0;
         r_victim <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            r_tag[i]   <= '0;
            r_count[i] <= '0;
         end
      end else if (table_clear) begin
         r_valid  <= '0;
         r_victim <= '0;
      end else if (w_cand) begin
         r_valid[w_sel_idx] <= 1'b1;
         r_tag[w_sel_idx]   <= br_target;
         r_count[w_sel_idx] <= w_fire ? '0 : w_new_count;
         if (!w_hit && !w_free_any) begin
            r_victim <= r_victim + IDX_W'(1);
         end
      end
   end

   // Trigger state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= PROF_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Trigger next-state and pulse generation
   always_comb begin
      w_next_state       = r_state;
      w_fire             = 1'b0;
      profiler_exception = 1'b0;
      case (r_state)
         PROF_IDLE: begin
            if (w_at_thresh) begin
               w_fire       = 1'b1;
               w_next_state = PROF_ARMED;
            end
         end
         PROF_ARMED: begin
            if (!fire_block) begin
               profiler_exception = 1'b1;
               w_next_state       = PROF_WAIT_ACK;
            end
         end
         PROF_WAIT_ACK: begin
            if (handler_ack) begin
               w_next_state = PROF_IDLE;
            end
         end
         default: w_next_state = PROF_IDLE;
      endcase
   end

   // Hot region bounds captured at the moment a trigger commits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hot_start <= '0;
         hot_end   <= '0;
      end else if (w_fire) begin
         hot_start <= br_target;
         hot_end   <= br_pc;
      end
   end

   assign busy = (r_state != PROF_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_profiler_trigger.sv
`default_nettype none
// ============================================================================
// Module      : tb_profiler_trigger
// Description : Directed self-checking bench for profiler_trigger
//               (ENTRIES=2, THRESHOLD=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_profiler_trigger;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        table_clear;
   logic        br_valid;
   logic        br_taken;
   logic [31:0] br_pc;
   logic [31:0] br_target;
   logic        fire_block;
   logic        handler_ack;
   logic        profiler_exception;
   logic [31:0] hot_start;
   logic [31:0] hot_end;
   logic        busy;

   int checks   = 0;
   int failures = 0;
   logic seen;

   profiler_trigger #(
      .ENTRIES   (2),
      .COUNT_W   (10),
      .THRESHOLD (4)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .enable             (enable),
      .table_clear        (table_clear),
      .br_valid           (br_valid),
      .br_taken           (br_taken),
      .br_pc              (br_pc),
      .br_target          (br_target),
      .fire_block         (fire_block),
      .handler_ack        (handler_ack),
      .profiler_exception (profiler_exception),
      .hot_start          (hot_start),
      .hot_end            (hot_end),
      .busy               (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic br(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
      br_valid  = 1'b1;
      br_taken  = tk;
      br_pc     = pc;
      br_target = tgt;
      cyc();
      br_valid  = 1'b0;
      br_taken  = 1'b0;
   endtask

   task automatic ack();
      handler_ack = 1'b1;
      cyc();
      handler_ack = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; table_clear = 1'b0; br_valid = 1'b0;
      br_taken = 1'b0; br_pc = '0; br_target = '0; fire_block = 1'b0;
      handler_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_exc",   {31'd0, profiler_exception}, 32'd0);
      chk("rst_busy",  {31'd0, busy}, 32'd0);
      chk("rst_start", hot_start, 32'd0);
      chk("rst_end",   hot_end, 32'd0);
      rst_n = 1'b1; enable = 1'b1;
      cyc();

      // 1: four taken backward branches reach the threshold
      repeat (3) br(32'h1040, 32'h1000, 1'b1);
      chk("t1_busy_early", {31'd0, busy}, 32'd0);
      br(32'h1040, 32'h1000, 1'b1);
      chk("t1_busy",  {31'd0, busy}, 32'd1);
      chk("t1_pulse", {31'd0, profiler_exception}, 32'd1);
      chk("t1_start", hot_start, 32'h1000);
      chk("t1_end",   hot_end, 32'h1040);
      cyc();
      chk("t1_pulse_width", {31'd0, profiler_exception}, 32'd0);
      chk("t1_wait_busy",   {31'd0, busy}, 32'd1);
      ack();
      chk("t1_ack_busy", {31'd0, busy}, 32'd0);

      // 2: forward, not-taken and disabled branches are ignored
      seen = 1'b0;
      repeat (4) begin
         br(32'h1000, 32'h1040, 1'b1);
         seen = seen | busy | profiler_exception;
      end
      repeat (100) begin
         br(32'h1040, 32'h1000, 1'b0);
         seen = seen | busy | profiler_exception;
      end
      enable = 1'b0;
      repeat (5) begin
         br(32'h1040, 32'h1000, 1'b1);
         seen = seen | busy | profiler_exception;
      end
      enable = 1'b1;
      chk("t2_quiet", {31'd0, seen}, 32'd0);

      // 3: replacement with two entries: C evicts A, D evicts B
      table_clear = 1'b1;
      cyc();
      table_clear = 1'b0;
      br(32'h3100, 32'h3000, 1'b1);
      br(32'h4100, 32'h4000, 1'b1);
      br(32'h5100, 32'h5000, 1'b1);
      br(32'h6100, 32'h6000, 1'b1);
      chk("t3_no_fire", {31'd0, busy}, 32'd0);
      repeat (3) br(32'h5100, 32'h5000, 1'b1);
      chk("t3_c_busy",  {31'd0, busy}, 32'd1);
      chk("t3_c_start", hot_start, 32'h5000);
      chk("t3_c_end",   hot_end, 32'h5100);
      cyc();
      ack();
      repeat (3) br(32'h6100, 32'h6000, 1'b1);
      chk("t3_d_busy",  {31'd0, busy}, 32'd1);
      chk("t3_d_start", hot_start, 32'h6000);
      cyc();
      ack();

      // 4: fire_block delays the pulse; ack and enable=0 while armed are ignored
      fire_block = 1'b1;
      repeat (4) br(32'h5100, 32'h5000, 1'b1);
      chk("t4_armed_busy", {31'd0, busy}, 32'd1);
      chk("t4_blocked",    {31'd0, profiler_exception}, 32'd0);
      handler_ack = 1'b1;
      cyc();
      handler_ack = 1'b0;
      chk("t4_ack_ignored", {31'd0, busy}, 32'd1);
      repeat (3) cyc();
      chk("t4_held", {31'd0, profiler_exception}, 32'd0);
      enable = 1'b0;
      fire_block = 1'b0;
      #1;
      chk("t4_pulse", {31'd0, profiler_exception}, 32'd1);
      cyc();
      chk("t4_pulse_width", {31'd0, profiler_exception}, 32'd0);
      chk("t4_wait_busy",   {31'd0, busy}, 32'd1);
      enable = 1'b1;

      // 5: threshold reached while awaiting ack is not queued, re-fires later
      seen = 1'b0;
      repeat (4) begin
         br(32'h6100, 32'h6000, 1'b1);
         seen = seen | profiler_exception;
      end
      chk("t5_no_pulse",   {31'd0, seen}, 32'd0);
      chk("t5_start_kept", hot_start, 32'h5000);
      ack();
      chk("t5_ack_busy", {31'd0, busy}, 32'd0);
      br(32'h6200, 32'h6000, 1'b1);
      chk("t5_refire", {31'd0, profiler_exception}, 32'd1);
      chk("t5_start",  hot_start, 32'h6000);
      chk("t5_end",    hot_end, 32'h6200);
      cyc();
      ack();

      // 6: table_clear beats a coincident hit; reset drops an armed trigger
      repeat (2) br(32'h5100, 32'h5000, 1'b1);
      table_clear = 1'b1;
      br(32'h5100, 32'h5000, 1'b1);
      table_clear = 1'b0;
      repeat (3) br(32'h5100, 32'h5000, 1'b1);
      chk("t6_cleared", {31'd0, busy}, 32'd0);
      fire_block = 1'b1;
      br(32'h5100, 32'h5000, 1'b1);
      chk("t6_armed", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_busy",  {31'd0, busy}, 32'd0);
      chk("t6_rst_start", hot_start, 32'd0);
      fire_block = 1'b0;
      cyc();
      rst_n = 1'b1;
      cyc();
      chk("t6_no_pulse", {31'd0, profiler_exception}, 32'd0);
      chk("t6_idle",     {31'd0, busy}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
